// File: rtl/change_dispenser.sv
// change_dispenser: pays a refund balance to the coin hopper greedily, largest coin first,
// within per-denomination stock, one coin per valid/ready handshake.
module change_dispenser #(
  parameter int W = 16,
  parameter int STOCK_W = 8,
  parameter int STOCK_0P5 = 50,
  parameter int STOCK_1 = 50,
  parameter int STOCK_5 = 20,
  parameter int STOCK_10 = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refundReq,
  input  logic [W-1:0] refundAmt,
  input  logic         refillBtn,
  input  logic         hopperReady,
  output logic         coinValid,
  output logic [1:0]   coinKind,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] shortfall
);
  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, GAP, DONE} state_t;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [4*STOCK_W-1:0] FULL = {STOCK_W'(STOCK_10), STOCK_W'(STOCK_5),
                                           STOCK_W'(STOCK_1), STOCK_W'(STOCK_0P5)};
  state_t state, state_n;
  logic [W-1:0] remaining;
  logic [STOCK_W-1:0] stock [4];
  logic [GW-1:0] gap;
  logic found;
  logic [1:0] pick;
  function automatic logic [W-1:0] value(input logic [1:0] k);
    return k == 2'd3 ? W'(20) : k == 2'd2 ? W'(10) : k == 2'd1 ? W'(2) : W'(1);
  endfunction
  // ascending scan: the last affordable, stocked kind is the largest
  always_comb begin
    found = 1'b0;
    pick = 2'd0;
    for (int i = 0; i < 4; i++)
      if (remaining >= value(2'(i)) && stock[i] != '0) begin
        found = 1'b1;
        pick = 2'(i);
      end
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  // SELECT is itself one dead cycle, so GAP only covers the remaining GAP_CYCLES-1
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = refundReq ? SELECT : IDLE;
      SELECT:  state_n = found ? ISSUE : DONE;
      ISSUE:   state_n = !hopperReady ? ISSUE : GAP_CYCLES > 1 ? GAP : SELECT;
      GAP:     state_n = gap <= GW'(1) ? SELECT : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    coinValid = state == ISSUE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      remaining <= '0;
      coinKind <= '0;
      shortfall <= '0;
      gap <= '0;
      for (int i = 0; i < 4; i++) stock[i] <= FULL[i*STOCK_W +: STOCK_W];
    end else begin
      if (state == IDLE && refillBtn)
        for (int i = 0; i < 4; i++) stock[i] <= FULL[i*STOCK_W +: STOCK_W];
      case (state)
        IDLE:
          if (refundReq) begin
            remaining <= refundAmt;
            shortfall <= '0;
          end
        SELECT:
          if (found) coinKind <= pick;
          else shortfall <= remaining;
        ISSUE:
          if (hopperReady) begin
            remaining <= remaining - value(coinKind);
            stock[coinKind] <= stock[coinKind] - 1'b1;
            gap <= GW'(GAP_CYCLES - 1);
          end
        GAP: gap <= gap - 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: random payouts against a greedy arithmetic model, scoreboarded per coin and per done.
module tb_change_dispenser;
  localparam int GAP = 2;
  logic clk = 0, rst = 0, refundReq = 0, refillBtn = 0, hopperReady = 0;
  logic [15:0] refundAmt = '0;
  logic coinValid, busy, done;
  logic [1:0] coinKind;
  logic [15:0] shortfall;
  int tests = 0, fails = 0;
  int mode = 1;
  bit inject = 0;
  int val[4] = '{1, 2, 10, 20};
  int full[4] = '{50, 50, 20, 10};
  int stock_m[4];
  int exp_coins[$], exp_short[$];
  bit in_gap = 0, prev_stall = 0;
  int gap_cnt = 0;
  logic [1:0] prev_kind = '0;

  change_dispenser dut (
    .clk(clk), .rst(rst), .refundReq(refundReq), .refundAmt(refundAmt),
    .refillBtn(refillBtn), .hopperReady(hopperReady), .coinValid(coinValid),
    .coinKind(coinKind), .busy(busy), .done(done), .shortfall(shortfall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic refill_m();
    for (int d = 0; d < 4; d++) stock_m[d] = full[d];
  endtask

  task automatic model_pay(input int amt);
    int rem = amt;
    bit f;
    do begin
      f = 0;
      for (int d = 3; d >= 0; d--)
        if (!f && val[d] <= rem && stock_m[d] > 0) begin
          f = 1;
          exp_coins.push_back(d);
          rem -= val[d];
          stock_m[d]--;
        end
    end while (f);
    exp_short.push_back(rem);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    refundReq = 0;
    refillBtn = 0;
    hopperReady = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      if (inject && $urandom_range(0, 7) == 0) begin
        refundReq = 1;
        refundAmt = 16'($urandom_range(1, 100));
        refillBtn = 1'($urandom_range(0, 1));
      end
      cycle();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic pay(input int amt, input bit refill);
    wait_idle();
    refundReq = 1;
    refundAmt = 16'(amt);
    refillBtn = refill;
    if (refill) refill_m();
    model_pay(amt);
    cycle();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      in_gap = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", coinValid, 1);
        chk("hold_kind", coinKind, prev_kind);
      end
      if (coinValid && in_gap) begin
        chk("gap_len", gap_cnt, GAP);
        in_gap = 0;
      end else if (!coinValid && in_gap) gap_cnt++;
      if (coinValid && hopperReady) begin
        if (exp_coins.size() == 0) chk("unexpected_coin", coinKind, -1);
        else chk("coin_kind", coinKind, exp_coins.pop_front());
        in_gap = 1;
        gap_cnt = 0;
      end
      prev_stall = coinValid && !hopperReady;
      prev_kind = coinKind;
      if (done) begin
        chk("done_busy", busy, 1);
        if (exp_short.size() == 0) chk("unexpected_done", shortfall, -1);
        else chk("shortfall", shortfall, exp_short.pop_front());
        chk("coins_before_done", exp_coins.size(), 0);
        in_gap = 0;
      end
    end
  end

  initial begin
    refill_m();
    repeat (3) cycle();
    chk("rst_valid", coinValid, 0);
    chk("rst_kind", coinKind, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", shortfall, 0);
    rst = 1;
    cycle();
    pay(27, 0);
    chk("lat_select_valid", coinValid, 0);
    chk("lat_select_busy", busy, 1);
    cycle();
    chk("lat_issue_valid", coinValid, 1);
    chk("lat_issue_kind", coinKind, 3);
    pay(0, 0);
    chk("zero_busy", busy, 1);
    chk("zero_early_done", done, 0);
    cycle();
    chk("zero_done", done, 1);
    chk("zero_no_coin", coinValid, 0);
    mode = 2;
    pay(2, 0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", coinValid, 1);
      chk("bp_kind", coinKind, 1);
      if (i < 4) cycle();
    end
    mode = 1;
    cycle();
    chk("bp_last_valid", coinValid, 1);
    cycle();
    chk("bp_released", coinValid, 0);
    wait_idle();
    mode = 0;
    inject = 1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        refillBtn = 1;
        refill_m();
        cycle();
      end
      pay($urandom_range(0, 150), $urandom_range(0, 5) == 0);
    end
    inject = 0;
    wait_idle();
    mode = 2;
    pay(100, 1);
    for (int n = 0; n < 10 && !coinValid; n++) cycle();
    chk("pre_rst_valid", coinValid, 1);
    rst = 0;
    exp_coins.delete();
    exp_short.delete();
    refill_m();
    cycle();
    chk("midrst_valid", coinValid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1;
    mode = 1;
    pay(27, 0);
    mode = 0;
    for (int t = 0; t < 10; t++) pay($urandom_range(0, 200), 0);
    wait_idle();
    repeat (2) cycle();
    chk("coins_left", exp_coins.size(), 0);
    chk("dones_left", exp_short.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
